resp_router: RTL and testbench

//  Return path for the round-robin request arbiter. Tracks the port index of each granted read.

---
 rtl/resp_router.sv | 82 ++++++++
 tb/tb_resp_router.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/resp_router.sv
// resp_router: routes in-order responses back to the requester port that issued each read.
// Optional sticky orphan-response detection is built when RESP_ROUTER_ORPHAN_CHK_EN is defined.
module resp_router #(
  parameter int NUM_PORTS  = 64,
  parameter int SEL_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  issue_valid_i,
  input  logic [SEL_WIDTH-1:0]  issue_sel_i,
  output logic                  issue_ready_o,
  input  logic                  resp_valid_i,
  input  logic [DATA_WIDTH-1:0] resp_data_i,
  output logic [NUM_PORTS-1:0]  port_valid_o,
  output logic [DATA_WIDTH-1:0] port_data_o,
  output logic [SEL_WIDTH-1:0]  port_sel_o,
  output logic [CNT_WIDTH-1:0]  outstanding_o,
  output logic                  orphan_err_o
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [SEL_WIDTH-1:0]  tags_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]  port_valid_q, port_valid_d;
  logic [DATA_WIDTH-1:0] port_data_q, port_data_d;
  logic [SEL_WIDTH-1:0]  port_sel_q, port_sel_d;
  logic [SEL_WIDTH-1:0]  tag;
  logic                  push, pop;
  assign issue_ready_o = cnt_q != CNT_WIDTH'(DEPTH);
  assign push          = issue_valid_i & issue_ready_o;
  assign pop           = resp_valid_i & (cnt_q != '0);
  assign tag           = tags_q[rd_ptr_q];
  // Next-state for pointers, occupancy and the registered port strobe/payload.
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d        = cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    port_valid_d = pop ? NUM_PORTS'(1) << tag : '0;
    port_sel_d   = pop ? tag : port_sel_q;
    port_data_d  = pop ? resp_data_i : port_data_q;
  end
  // Control and output registers; reset discards every held tag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      port_valid_q <= '0;
      port_sel_q   <= '0;
      port_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      port_valid_q <= port_valid_d;
      port_sel_q   <= port_sel_d;
      port_data_q  <= port_data_d;
    end
  end
  // Tag storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push) tags_q[wr_ptr_q] <= issue_sel_i;
  end
  assign port_valid_o  = port_valid_q;
  assign port_sel_o    = port_sel_q;
  assign port_data_o   = port_data_q;
  assign outstanding_o = cnt_q;
`ifdef RESP_ROUTER_ORPHAN_CHK_EN
  logic orphan_q;
  // Sticky flag for a response that arrived with no tag to route it.
  always_ff @(posedge clk) begin
    if (!rstn) orphan_q <= 1'b0;
    else       orphan_q <= orphan_q | (resp_valid_i & (cnt_q == '0));
  end
  assign orphan_err_o = orphan_q;
`else
  assign orphan_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_resp_router.sv
// tb_resp_router: directed checks of routing, ordering, full/wrap behaviour, orphans and reset.
module tb_resp_router;
  localparam int NP = 4, SW = 2, DW = 32, DEPTH = 8, CW = 4;
`ifdef RESP_ROUTER_ORPHAN_CHK_EN
  localparam logic ORPH = 1'b1;
`else
  localparam logic ORPH = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  logic issue_valid = 1'b0, resp_valid = 1'b0, issue_ready, orphan_err;
  logic [SW-1:0] issue_sel = '0, port_sel;
  logic [DW-1:0] resp_data = '0, port_data;
  logic [NP-1:0] port_valid;
  logic [CW-1:0] outstanding;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  resp_router #(.NUM_PORTS(NP), .SEL_WIDTH(SW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn),
    .issue_valid_i(issue_valid), .issue_sel_i(issue_sel), .issue_ready_o(issue_ready),
    .resp_valid_i(resp_valid), .resp_data_i(resp_data),
    .port_valid_o(port_valid), .port_data_o(port_data), .port_sel_o(port_sel),
    .outstanding_o(outstanding), .orphan_err_o(orphan_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_port(input string tag, input logic [NP-1:0] pv, input logic [SW-1:0] ps, input logic [DW-1:0] pd);
    chk({tag, ".valid"}, 32'(port_valid), 32'(pv));
    chk({tag, ".sel"}, 32'(port_sel), 32'(ps));
    chk({tag, ".data"}, port_data, pd);
  endtask
  initial begin
    tick();
    tick();
    rstn = 1'b1;
    chk("rst.out", 32'(outstanding), 0);
    chk("rst.ready", 32'(issue_ready), 1);
    chk("rst.orphan", 32'(orphan_err), 0);
    chk_port("rst", 4'b0000, 2'd0, 32'h0);
    // single trip
    issue_valid = 1'b1; issue_sel = 2'd2;
    tick();
    issue_valid = 1'b0;
    chk("t1.out1", 32'(outstanding), 1);
    tick();
    tick();
    resp_valid = 1'b1; resp_data = 32'hA5;
    tick();
    resp_valid = 1'b0;
    chk_port("t1.resp", 4'b0100, 2'd2, 32'hA5);
    chk("t1.out0", 32'(outstanding), 0);
    tick();
    chk_port("t1.hold", 4'b0000, 2'd2, 32'hA5);
    // ordering
    issue_valid = 1'b1;
    issue_sel = 2'd3; tick();
    issue_sel = 2'd0; tick();
    issue_sel = 2'd1; tick();
    issue_valid = 1'b0;
    chk("t2.out3", 32'(outstanding), 3);
    resp_valid = 1'b1;
    resp_data = 32'h11; tick();
    chk_port("t2.r0", 4'b1000, 2'd3, 32'h11);
    resp_data = 32'h22; tick();
    chk_port("t2.r1", 4'b0001, 2'd0, 32'h22);
    resp_data = 32'h33; tick();
    chk_port("t2.r2", 4'b0010, 2'd1, 32'h33);
    resp_valid = 1'b0;
    chk("t2.out0", 32'(outstanding), 0);
    // full: tags 0,1,2,3,0,1,2,3
    issue_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue_sel = SW'(i % 4);
      tick();
    end
    chk("t3.out8", 32'(outstanding), 8);
    chk("t3.notready", 32'(issue_ready), 0);
    issue_sel = 2'd3;
    tick();
    chk("t3.ignored", 32'(outstanding), 8);
    resp_valid = 1'b1; resp_data = 32'h100;
    tick();
    issue_valid = 1'b0; resp_valid = 1'b0;
    chk("t3.noreuse", 32'(outstanding), 7);
    chk("t3.ready", 32'(issue_ready), 1);
    chk_port("t3.r0", 4'b0001, 2'd0, 32'h100);
    resp_valid = 1'b1;
    for (int i = 1; i < 8; i++) begin
      resp_data = 32'h100 + 32'(i);
      tick();
      chk_port("t3.drain", NP'(1) << (i % 4), SW'(i % 4), 32'h100 + 32'(i));
    end
    resp_valid = 1'b0;
    chk("t3.empty", 32'(outstanding), 0);
    // wrap with concurrent issue and response
    issue_valid = 1'b1; issue_sel = 2'd0;
    tick();
    resp_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      issue_sel = SW'((k + 1) % 4);
      resp_data = 32'(k);
      tick();
      chk("t4.out", 32'(outstanding), 1);
      chk_port("t4.route", NP'(1) << (k % 4), SW'(k % 4), 32'(k));
    end
    issue_valid = 1'b0; resp_data = 32'h55;
    tick();
    resp_valid = 1'b0;
    chk_port("t4.last", 4'b0001, 2'd0, 32'h55);
    chk("t4.out0", 32'(outstanding), 0);
    // orphan
    resp_valid = 1'b1; resp_data = 32'hDEAD;
    tick();
    resp_valid = 1'b0;
    chk_port("t5.orphan", 4'b0000, 2'd0, 32'h55);
    chk("t5.out", 32'(outstanding), 0);
    chk("t5.err", 32'(orphan_err), 32'(ORPH));
    tick();
    tick();
    chk("t5.sticky", 32'(orphan_err), 32'(ORPH));
    // reset mid-stream
    issue_valid = 1'b1;
    issue_sel = 2'd1; tick();
    issue_sel = 2'd2; tick();
    issue_sel = 2'd3; tick();
    issue_valid = 1'b0;
    chk("t6.out3", 32'(outstanding), 3);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("t6.out0", 32'(outstanding), 0);
    chk("t6.ready", 32'(issue_ready), 1);
    chk("t6.errclr", 32'(orphan_err), 0);
    chk_port("t6.rst", 4'b0000, 2'd0, 32'h0);
    resp_valid = 1'b1; resp_data = 32'h77;
    tick();
    resp_valid = 1'b0;
    chk_port("t6.orphan", 4'b0000, 2'd0, 32'h0);
    chk("t6.err", 32'(orphan_err), 32'(ORPH));
    // pop while empty never bypasses a same-cycle push
    issue_valid = 1'b1; issue_sel = 2'd2; resp_valid = 1'b1; resp_data = 32'h88;
    tick();
    issue_valid = 1'b0;
    chk("t7.out1", 32'(outstanding), 1);
    chk_port("t7.nobypass", 4'b0000, 2'd0, 32'h0);
    resp_data = 32'h99;
    tick();
    resp_valid = 1'b0;
    chk_port("t7.route", 4'b0100, 2'd2, 32'h99);
    chk("t7.out0", 32'(outstanding), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
